// File: rtl/sqrt_pkg.sv
// Shared types for the iterative square-root unit: controller state encoding.
package sqrt_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } state_t;

endpackage

// File: rtl/control_path_if.sv
// Control/status bundle between the square-root controller and its datapath.
interface control_path_if;

    logic [1:0] N_i;
    logic       boot_o;
    logic       muxes_o;
    logic       ready_o;
    logic       wr_root_o;
    logic       wr_square_o;
    logic       root_o;

    modport master (
        input  N_i,
        output boot_o, muxes_o, ready_o, wr_root_o, wr_square_o, root_o
    );

    modport slave (
        output N_i,
        input  boot_o, muxes_o, ready_o, wr_root_o, wr_square_o, root_o
    );

endinterface

// File: rtl/control_path.sv
// Sequencing FSM for the square-root datapath: boot, root compare/update, square update.
// Outputs decode combinationally from state, and from the datapath status while in S1.
module control_path
    import sqrt_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    control_path_if.master bus
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S0;
        else        r_state <= w_next;
    end

    // Don't-care outputs are driven as literal X so synthesis is free to pick.
    always_comb begin
        w_next          = S0;
        bus.boot_o      = 1'b0;
        bus.muxes_o     = 1'b0;
        bus.ready_o     = 1'b0;
        bus.wr_root_o   = 1'b0;
        bus.wr_square_o = 1'b0;
        bus.root_o      = 1'b0;
        unique case (r_state)
            S0: begin
                w_next          = S1;
                bus.boot_o      = 1'b1;
                bus.muxes_o     = 1'bx;
                bus.ready_o     = 1'b1;
                bus.wr_root_o   = 1'b1;
                bus.wr_square_o = 1'b1;
                bus.root_o      = 1'bx;
            end
            S1: begin
                w_next      = bus.N_i[1] ? S2 : S1;
                bus.muxes_o = 1'b1;
                if (bus.N_i == 2'b00) begin
                    bus.wr_root_o = 1'b1;
                    bus.ready_o   = 1'b1;
                    bus.root_o    = 1'bx;
                end else begin
                    bus.root_o    = bus.N_i[1] & ~bus.N_i[0];
                end
            end
            S2: begin
                w_next          = S1;
                bus.wr_square_o = 1'b1;
                bus.ready_o     = 1'b1;
                bus.root_o      = 1'bx;
            end
            default: begin
                w_next          = S0;
                bus.boot_o      = 1'b1;
                bus.ready_o     = 1'b1;
                bus.wr_root_o   = 1'b1;
                bus.wr_square_o = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_control_path.sv
// Directed bench for control_path: reset, S1 decode, S1/S2 iteration, hold and async reset.
module tb_control_path;

    logic clk;
    logic rst_n;

    control_path_if bus ();

    control_path dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Observation bit order: {boot, muxes, wr_root, wr_square, root, ready}.
    // Mask bits are 0 where the required value is a don't-care.
    localparam logic [5:0] S0_EXP = 6'b101101;
    localparam logic [5:0] S0_MSK = 6'b101101;
    localparam logic [5:0] S2_EXP = 6'b000101;
    localparam logic [5:0] S2_MSK = 6'b111101;

    logic [5:0] s1_exp [4];
    logic [5:0] s1_msk [4];

    int n_checks;
    int n_fail;

    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] obs();
        return {bus.boot_o, bus.muxes_o, bus.wr_root_o, bus.wr_square_o, bus.root_o, bus.ready_o};
    endfunction

    task automatic test_reset();
        logic [5:0] o;
        rst_n   = 1'b0;
        bus.N_i = 2'b00;
        #1;
        o = obs();
        n_checks++;
        if ((o & S0_MSK) !== S0_EXP) begin
            n_fail++;
            $display("FAIL reset_asserted: got %b want %b (mask %b)", o, S0_EXP, S0_MSK);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.N_i = 2'(i);
            #1;
            o = obs();
            n_checks++;
            if ((o & S0_MSK) !== S0_EXP) begin
                n_fail++;
                $display("FAIL s0_hold N=%0d: got %b want %b (mask %b)", i, o, S0_EXP, S0_MSK);
            end
        end
    endtask

    task automatic test_s1_decode();
        logic [5:0] o;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            bus.N_i = 2'(i);
            #1;
            o = obs();
            n_checks++;
            if ((o & s1_msk[i]) !== s1_exp[i]) begin
                n_fail++;
                $display("FAIL s1_decode N=%0d: got %b want %b (mask %b)", i, o, s1_exp[i], s1_msk[i]);
            end
        end
    endtask

    task automatic test_s1_to_s2();
        logic [5:0] o;
        bus.N_i = 2'b11;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            bus.N_i = 2'(i);
            #1;
            o = obs();
            n_checks++;
            if ((o & S2_MSK) !== S2_EXP) begin
                n_fail++;
                $display("FAIL s2_decode N=%0d: got %b want %b (mask %b)", i, o, S2_EXP, S2_MSK);
            end
        end
    endtask

    task automatic test_s2_to_s1();
        logic [5:0] o;
        bus.N_i = 2'b11;
        @(posedge clk);
        #1;
        bus.N_i = 2'b00;
        #1;
        o = obs();
        n_checks++;
        if ((o & s1_msk[0]) !== s1_exp[0]) begin
            n_fail++;
            $display("FAIL s2_to_s1: got %b want %b (mask %b)", o, s1_exp[0], s1_msk[0]);
        end
    endtask

    task automatic test_s1_hold();
        logic [5:0] o;
        bus.N_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            o = obs();
            n_checks++;
            if (o !== s1_exp[1]) begin
                n_fail++;
                $display("FAIL s1_hold cycle %0d: got %b want %b", k, o, s1_exp[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] o;
        bus.N_i = 2'b10;
        #1;
        o = obs();
        n_checks++;
        if (o !== s1_exp[2]) begin
            n_fail++;
            $display("FAIL s1_pre_s2: got %b want %b", o, s1_exp[2]);
        end
        @(posedge clk);
        #1;
        o = obs();
        n_checks++;
        if ((o & S2_MSK) !== S2_EXP) begin
            n_fail++;
            $display("FAIL mid_in_s2: got %b want %b (mask %b)", o, S2_EXP, S2_MSK);
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = obs();
        n_checks++;
        if ((o & S0_MSK) !== S0_EXP) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %b want %b (mask %b)", o, S0_EXP, S0_MSK);
        end
        @(posedge clk);
        #1;
        o = obs();
        n_checks++;
        if ((o & S0_MSK) !== S0_EXP) begin
            n_fail++;
            $display("FAIL mid_reset_held: got %b want %b (mask %b)", o, S0_EXP, S0_MSK);
        end
        rst_n = 1'b1;
        #1;
        o = obs();
        n_checks++;
        if ((o & S0_MSK) !== S0_EXP) begin
            n_fail++;
            $display("FAIL mid_reset_released: got %b want %b (mask %b)", o, S0_EXP, S0_MSK);
        end
        @(posedge clk);
        #1;
        o = obs();
        n_checks++;
        if (o !== s1_exp[2]) begin
            n_fail++;
            $display("FAIL mid_reset_to_s1: got %b want %b", o, s1_exp[2]);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        s1_exp[0] = 6'b011001; s1_msk[0] = 6'b111101;
        s1_exp[1] = 6'b010000; s1_msk[1] = 6'b111111;
        s1_exp[2] = 6'b010010; s1_msk[2] = 6'b111111;
        s1_exp[3] = 6'b010000; s1_msk[3] = 6'b111111;

        test_reset();
        test_s1_decode();
        test_s1_to_s2();
        test_s2_to_s1();
        test_s1_hold();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
